// File: rtl/imm_gen_pkg.sv
// Shared types for the pipelined RV immediate generator.
// Opcodes, format codes, payload struct and skid states.
package imm_gen_pkg;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [2:0] STAT_ILL = 3'd6;

  // imm holds the 32-bit sign-extended value; widened to XLEN at the output
  typedef struct packed {
    logic [31:0] imm;
    fmt_e        fmt;
    logic        illegal;
  } imm_pay_t;

  typedef enum logic [1:0] {
    SK_EMPTY = 2'd0,
    SK_ONE   = 2'd1,
    SK_FULL  = 2'd2
  } skid_e;

  function automatic logic [63:0] sext64(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational opcode decode: raw instruction to immediate payload.
// XLEN=64 additionally accepts the RV64 word-op opcodes.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0] inst_i,
  output imm_pay_t    pay_o
);

  logic [6:0] op;
  logic       rv64;
  logic       is_i, is_s, is_b, is_u, is_j, is_r;

  assign op   = inst_i[6:0];
  assign rv64 = (XLEN == 64);

  assign is_i = (op == OPC_OP_IMM) | (op == OPC_LOAD)
              | (op == OPC_JALR) | (op == OPC_SYSTEM)
              | (rv64 & (op == OPC_OP_IMM32));
  assign is_s = (op == OPC_STORE);
  assign is_b = (op == OPC_BRANCH);
  assign is_u = (op == OPC_LUI) | (op == OPC_AUIPC);
  assign is_j = (op == OPC_JAL);
  assign is_r = (op == OPC_OP) | (rv64 & (op == OPC_OP32));

  always_comb begin
    pay_o     = '0;
    pay_o.fmt = FMT_R;
    unique case (1'b1)
      is_i: begin
        pay_o.fmt = FMT_I;
        pay_o.imm = {{20{inst_i[31]}}, inst_i[31:20]};
      end
      is_s: begin
        pay_o.fmt = FMT_S;
        pay_o.imm = {{20{inst_i[31]}}, inst_i[31:25],
                     inst_i[11:7]};
      end
      is_b: begin
        pay_o.fmt = FMT_B;
        pay_o.imm = {{19{inst_i[31]}}, inst_i[31],
                     inst_i[7], inst_i[30:25],
                     inst_i[11:8], 1'b0};
      end
      is_u: begin
        pay_o.fmt = FMT_U;
        pay_o.imm = {inst_i[31:12], 12'b0};
      end
      is_j: begin
        pay_o.fmt = FMT_J;
        pay_o.imm = {{11{inst_i[31]}}, inst_i[31],
                     inst_i[19:12], inst_i[20],
                     inst_i[30:21], 1'b0};
      end
      is_r: begin
        pay_o.fmt = FMT_R;
      end
      default: begin
        pay_o.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator behind a 2-slot skid buffer.
// Define IMM_GEN_STATS_EN to build per-format output counters.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32
`ifdef IMM_GEN_STATS_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [31:0]      inst_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [XLEN-1:0]  imm_o,
  output logic [2:0]       fmt_o,
  output logic             illegal_o
`ifdef IMM_GEN_STATS_EN
  ,
  input  logic [2:0]       stat_sel_i,
  output logic [CNT_W-1:0] stat_cnt_o
`endif
);

  imm_pay_t dec_pay;
  imm_pay_t out_q, out_d;
  imm_pay_t skid_q, skid_d;
  skid_e    state_q, state_d;
  logic     rdy_q;
  logic     in_fire, out_fire;

  imm_decode #(.XLEN(XLEN)) u_dec (
    .inst_i (inst_i),
    .pay_o  (dec_pay)
  );

  assign ready_o  = rdy_q;
  assign valid_o  = (state_q != SK_EMPTY);
  assign in_fire  = valid_i & ready_o;
  assign out_fire = valid_o & ready_i;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    unique case (state_q)
      SK_EMPTY: begin
        if (in_fire) begin
          out_d   = dec_pay;
          state_d = SK_ONE;
        end
      end
      SK_ONE: begin
        case ({in_fire, out_fire})
          2'b11: out_d = dec_pay;
          2'b01: state_d = SK_EMPTY;
          2'b10: begin
            skid_d  = dec_pay;
            state_d = SK_FULL;
          end
          default: ;
        endcase
      end
      SK_FULL: begin
        if (out_fire) begin
          out_d   = skid_q;
          state_d = SK_ONE;
        end
      end
      default: state_d = SK_EMPTY;
    endcase
  end

  // ready is registered so it never depends on ready_i combinationally
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= SK_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
      rdy_q   <= (state_d != SK_FULL);
    end
  end

  assign fmt_o     = out_q.fmt;
  assign illegal_o = out_q.illegal;

  if (XLEN == 64) begin : g_x64
    assign imm_o = sext64(out_q.imm);
  end else begin : g_x32
    assign imm_o = out_q.imm;
  end

`ifdef IMM_GEN_STATS_EN
  logic [CNT_W-1:0] cnt_q [8];
  logic [2:0]       cnt_idx;

  assign cnt_idx = out_q.illegal ? STAT_ILL : out_q.fmt;

  // slot 7 is never written, so selecting it reads back zero
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
    end else if (out_fire && (cnt_q[cnt_idx] != '1)) begin
      cnt_q[cnt_idx] <= cnt_q[cnt_idx] + 1'b1;
    end
  end

  assign stat_cnt_o = cnt_q[stat_sel_i];
`endif

endmodule
